// File: rtl/wb_ram_pl.sv
// wb_ram_pl: pipelined Wishbone B4 slave RAM.
//
// A word-addressed RAM of DEPTH entries, DATA_W bits each, with byte lane
// enables. Every accepted request gets exactly one response (ack_o or err_o).
// The response arrives LATENCY cycles after the request is accepted, and
// responses come back in order. At most MAX_OUTSTANDING requests may be
// accepted but not yet answered. When that limit is reached, stall_o holds off
// the master. Word indices at or beyond DEPTH terminate with err_o. Dropping
// cyc_i cancels every response still in flight.
//
// Ports:
//   clk_i    : clock; all state changes on its rising edge
//   rst_n_i  : asynchronous active-low reset
//   addr_i   : byte address; word index = addr_i >> ADDR_LSB
//   data_i   : write data
//   data_o   : read data; meaningful only while ack_o is high (0 otherwise)
//   sel_i    : byte lane enables
//   cyc_i    : bus cycle; low at an edge aborts all in-flight responses
//   stb_i    : strobe
//   cti_i    : cycle type; accepted and ignored
//   we_i     : write enable
//   ack_o    : normal termination
//   err_o    : error termination (word index out of range)
//   stall_o  : pipeline stall, driven only from registered state
module wb_ram_pl #(
  parameter int DATA_W          = 32,
  parameter int DEPTH           = 16384,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 4,
  localparam int SEL_W          = DATA_W / 8,
  localparam int ADDR_LSB       = $clog2(SEL_W)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  input  logic [SEL_W-1:0]  sel_i,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic [2:0]        cti_i,
  input  logic              we_i,
  output logic              ack_o,
  output logic              err_o,
  output logic              stall_o
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  // Elaboration-time parameter sanity checks.
  if ((DATA_W != 32) && (DATA_W != 64)) begin : g_bad_data_w
    $error("wb_ram_pl: DATA_W must be 32 or 64");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("wb_ram_pl: DEPTH must be at least 2");
  end
  if ((LATENCY < 1) || (LATENCY > 4)) begin : g_bad_latency
    $error("wb_ram_pl: LATENCY must be in 1..4");
  end
  if ((MAX_OUTSTANDING < 1) || (MAX_OUTSTANDING > 8)) begin : g_bad_max_out
    $error("wb_ram_pl: MAX_OUTSTANDING must be in 1..8");
  end

  // Outstanding-request counter update. It saturates at both ends, so it can
  // never wrap even if the master ignores stall_o.
  function automatic logic [CNT_W-1:0] count_next(input logic [CNT_W-1:0] cnt,
                                                  input logic             inc,
                                                  input logic             dec);
    logic [CNT_W-1:0] nxt;
    nxt = cnt;
    if (inc && !dec) begin
      if (cnt != CNT_MAX) nxt = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt != '0) nxt = cnt - CNT_W'(1);
    end
    return nxt;
  endfunction

  // Storage. Contents are not reset.
  logic [DATA_W-1:0] mem [DEPTH];

  // Response pipeline: control is reset, data is not.
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [LATENCY-1:0] err_q, err_d;
  logic [DATA_W-1:0]  rdata_q [LATENCY];
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [31:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             in_range;
  logic             accept;
  logic             resp;
  logic             wr_en;
  logic             rd_en;
  logic             unused_ok;

  // cti_i is accepted for bus compatibility; no burst prediction uses it.
  assign unused_ok = ^cti_i;

  // Request decode (accept edge).
  // The range check uses the full shifted address, so aliases above DEPTH
  // (including those that would wrap in IDX_W bits) are rejected.
  assign word_idx = addr_i >> ADDR_LSB;
  assign in_range = (word_idx < 32'(DEPTH));
  assign mem_idx  = word_idx[IDX_W-1:0];

  assign resp     = vld_q[LATENCY-1];
  assign stall_o  = (cnt_q == CNT_MAX) & ~resp;
  assign accept   = cyc_i & stb_i & ~stall_o;
  assign wr_en    = accept & we_i & in_range;
  assign rd_en    = accept & ~we_i & in_range;

  // The write commits at the accept edge. A read accepted on any later edge
  // therefore samples the updated word, with no forwarding path needed.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < SEL_W; b++) begin
        if (sel_i[b]) mem[mem_idx][b*8 +: 8] <= data_i[b*8 +: 8];
      end
    end
  end

  // Response pipeline stages (accept edge -> ack/err).
  // Stage 0 is loaded at the accept edge, and the last stage drives the
  // outputs. A request accepted at edge N is therefore visible after edge
  // N+LATENCY-1. A low cyc_i flushes every stage at that edge.
  always_comb begin
    vld_d = '0;
    err_d = '0;
    if (cyc_i) begin
      vld_d[0] = accept;
      err_d[0] = accept & ~in_range;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        err_d[i] = err_q[i-1];
      end
    end
  end

  always_comb begin
    cnt_d = '0;
    if (cyc_i) cnt_d = count_next(cnt_q, accept, resp);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_q <= '0;
      err_q <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  // Read data travels beside the valid bits. Writes and errors carry zero.
  always_ff @(posedge clk_i) begin
    rdata_q[0] <= rd_en ? mem[mem_idx] : '0;
    for (int i = 1; i < LATENCY; i++) begin
      rdata_q[i] <= rdata_q[i-1];
    end
  end

  // Output stage.
  // data_o is gated by ack_o. It therefore reads 0 in reset and on error
  // responses, even though the data stages themselves are never reset.
  assign ack_o  = vld_q[LATENCY-1] & ~err_q[LATENCY-1];
  assign err_o  = vld_q[LATENCY-1] &  err_q[LATENCY-1];
  assign data_o = ack_o ? rdata_q[LATENCY-1] : '0;

endmodule

// File: tb/tb_wb_ram_pl.sv
module tb_wb_ram_pl;

  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int LAT   = 3;
  localparam int MAXO  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   addr;
  logic [DW-1:0] dat;
  logic [DW-1:0] data_o;
  logic [3:0]    sel;
  logic          cyc, stb, we;
  logic [2:0]    cti;
  logic          ack_o, err_o, stall_o;

  wb_ram_pl #(
    .DATA_W(DW), .DEPTH(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .addr_i(addr), .data_i(dat), .data_o(data_o),
    .sel_i(sel), .cyc_i(cyc), .stb_i(stb), .cti_i(cti), .we_i(we),
    .ack_o(ack_o), .err_o(err_o), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Reference model: word array plus an in-order queue of pending responses.
  // Each queue entry records the edge after which its response must be visible.
  typedef struct {
    int          due;
    bit          err;
    bit          we;
    logic [31:0] data;
  } rsp_t;

  rsp_t        q[$];
  logic [31:0] mmem [DEPTH];
  int          edge_n = 0;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          obs_acks = 0;
  int          obs_errs = 0;
  int          obs_stalls = 0;
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock cycle. Outputs are checked mid-cycle, and the model
  // is then updated at the rising edge.
  task automatic tick(output bit acc);
    bit   resp;
    bit   exp_stall;
    rsp_t e;
    int   idx;
    @(negedge clk);
    resp      = (q.size() > 0) && (q[0].due == edge_n);
    exp_stall = (q.size() == MAXO) && !resp;
    if (resp) e = q[0];
    else begin
      e.due = 0; e.err = 1'b0; e.we = 1'b0; e.data = '0;
    end
    if (ack_o === 1'b1) begin obs_acks++; last_rd = data_o; end
    if (err_o === 1'b1) obs_errs++;
    if (stall_o === 1'b1) obs_stalls++;
    chk("stall_o", stall_o, exp_stall);
    chk("ack_o", ack_o, resp & ~e.err);
    chk("err_o", err_o, resp & e.err);
    if (!rst_n || (resp && (e.err || !e.we))) chk("data_o", data_o, e.data);
    acc = rst_n && cyc && stb && !exp_stall;
    @(posedge clk);
    edge_n++;
    if (resp) void'(q.pop_front());
    if (acc) begin
      idx    = int'(addr >> 2);
      e.due  = edge_n + LAT - 1;
      e.we   = we;
      e.err  = (idx >= DEPTH);
      e.data = '0;
      if (!e.err) begin
        if (we) begin
          for (int b = 0; b < 4; b++) if (sel[b]) mmem[idx][b*8 +: 8] = dat[b*8 +: 8];
        end else begin
          e.data = mmem[idx];
        end
      end
      q.push_back(e);
    end
    if (!cyc || !rst_n) q.delete();
    #1;
  endtask

  task automatic drain();
    bit acc;
    int guard = 0;
    stb = 1'b0;
    while ((q.size() > 0) && (guard < 20)) begin
      tick(acc);
      guard++;
    end
    tick(acc);
  endtask

  task automatic req(input bit w, input int word, input logic [31:0] d, input logic [3:0] s);
    bit acc = 1'b0;
    int guard = 0;
    cyc = 1'b1; stb = 1'b1; we = w; dat = d; sel = s;
    addr = 32'(word) * 4 + 32'($urandom_range(0, 3));
    while (!acc && (guard < 20)) begin
      tick(acc);
      guard++;
    end
    drain();
  endtask

  function automatic int pick_word();
    int r = int'($urandom_range(0, 15));
    if (r < 8)  return r;
    if (r < 12) return 996 + (r - 8);
    if (r < 14) return 1000 + (r - 12);
    return 1029;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int base, base2, n;

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; dat = '0; sel = '0; cti = '0;
    for (int i = 0; i < DEPTH; i++) mmem[i] = '0;

    // Reset held for three cycles with outputs idle.
    for (int i = 0; i < 3; i++) tick(acc);
    rst_n = 1'b1;
    tick(acc);

    // Give every word used later a known value.
    for (int w = 0; w < 8; w++)     req(1'b1, w, $urandom, 4'hF);
    for (int w = 996; w < 1000; w++) req(1'b1, w, $urandom, 4'hF);

    // Write a word, then read it back.
    req(1'b1, 4, 32'hDEADBEEF, 4'hF);
    req(1'b0, 4, 32'h0, 4'hF);
    chk("rd_deadbeef", last_rd, 32'hDEADBEEF);

    // Byte lane enables.
    req(1'b1, 2, 32'h11223344, 4'hF);
    req(1'b1, 2, 32'hAABBCCDD, 4'h5);
    req(1'b0, 2, 32'h0, 4'h0);
    chk("rd_bytelanes", last_rd, 32'h11BB33DD);

    // A write with sel=0 is acknowledged and leaves the word unchanged.
    base = obs_acks;
    req(1'b1, 2, 32'hFFFFFFFF, 4'h0);
    chk("sel0_ack", obs_acks - base, 1);
    req(1'b0, 2, 32'h0, 4'h0);
    chk("sel0_keep", last_rd, 32'h11BB33DD);

    // Six back-to-back reads with stb held. Throttling must stall the master.
    base = obs_acks; base2 = obs_stalls; n = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    for (int g = 0; (g < 40) && (n < 6); g++) begin
      addr = 32'(n) * 4;
      tick(acc);
      if (acc) n++;
    end
    drain();
    chk("six_acks", obs_acks - base, 6);
    chk("stall_seen", (obs_stalls - base2) > 0, 1);

    // Out-of-range requests.
    base = obs_errs; base2 = obs_acks;
    req(1'b0, 1000, 32'h0, 4'hF);
    chk("oor_read_err", obs_errs - base, 1);
    chk("oor_read_noack", obs_acks - base2, 0);
    req(1'b1, 1029, 32'hCAFEF00D, 4'hF);   // word index 1029 aliases word 5
    req(1'b0, 5, 32'h0, 4'hF);
    chk("oor_write_noalias", last_rd, mmem[5]);
    req(1'b1, 999, 32'h5A5AA5A5, 4'hF);
    req(1'b0, 999, 32'h0, 4'hF);
    chk("rd_word999", last_rd, 32'h5A5AA5A5);

    // Abort: two reads accepted, then cyc_i dropped for one cycle.
    base = obs_acks + obs_errs; n = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'd12;
    for (int g = 0; (g < 20) && (n < 2); g++) begin
      tick(acc);
      if (acc) n++;
    end
    cyc = 1'b0; stb = 1'b0;
    tick(acc);
    cyc = 1'b1;
    for (int i = 0; i < 6; i++) tick(acc);
    chk("abort_no_resp", (obs_acks + obs_errs) - base, 0);
    stb = 1'b1; addr = 32'd12;
    chk("post_abort_stall", stall_o, 1'b0);
    tick(acc);
    drain();
    chk("post_abort_rd", last_rd, mmem[3]);

    // Asynchronous reset with reads in flight.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'd4;
    tick(acc);
    tick(acc);
    stb = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ack", ack_o, 1'b0);
    chk("async_rst_err", err_o, 1'b0);
    chk("async_rst_stall", stall_o, 1'b0);
    q.delete();
    cyc = 1'b0;
    tick(acc);
    tick(acc);
    rst_n = 1'b1;
    cyc = 1'b1;
    for (int i = 0; i < 4; i++) tick(acc);

    // Randomized traffic, including occasional aborts and out-of-range words.
    for (int i = 0; i < 1500; i++) begin
      cyc  = ($urandom_range(0, 15) != 0);
      stb  = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1);
      addr = 32'(pick_word()) * 4 + 32'($urandom_range(0, 3));
      dat  = $urandom;
      sel  = 4'($urandom_range(0, 15));
      cti  = 3'($urandom_range(0, 7));
      tick(acc);
    end
    cyc = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
